mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares one multi-cycle SRAM port between the IF stage (instruction fetch) and the MEM stage
//  (load/store) of the ARM pipeline. Grants one requester at a time and sequences the wait states.
//  Returns per-requester read data and a one-cycle ready pulse.
//  Drives the pipeline freeze while any granted or pending access is outstanding.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  WAIT_CYCLES  4   SRAM access cycles per transfer, legal range 1..15
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  if_req     in   1       fetch request; held until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched word, registered
//  if_ready   out  1       one-cycle pulse, fetch complete
//  mem_req    in   1       data request; held until mem_ready
//  mem_we     in   1       1=store, 0=load
//  mem_addr   in   ADDR_W  data address
//  mem_wdata  in   DATA_W  store data
//  mem_rdata  out  DATA_W  load data, registered
//  mem_ready  out  1       one-cycle pulse, data access complete
//  sram_en    out  1       SRAM enable
//  sram_we    out  1       SRAM write enable
//  sram_addr  out  ADDR_W  SRAM address
//  sram_wdata out  DATA_W  SRAM write data
//  sram_rdata in   DATA_W  SRAM read data, valid in the last ACCESS cycle
//  freeze     out  1       (if_req & ~if_ready) | (mem_req & ~mem_ready), combinational
//  busy       out  1       1 when state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, asynchronous):
//    - state=IDLE; cnt=0; last_owner=IF, so MEM wins the first tie.
//    - All registered outputs, including if_rdata and mem_rdata, are 0.
//    - sram_en and sram_we drop immediately. An access in flight is abandoned with no ready pulse.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE.
//    - IDLE: MEM only -> grant MEM; IF only -> grant IF.
//    - IDLE, both requesting -> grant the owner that is not last_owner (round-robin, no starvation).
//    - IDLE, no request -> stay in IDLE.
//    - Grant latches owner, address, we and wdata, loads cnt=WAIT_CYCLES-1, then moves to ACCESS.
//    - IF grants force we=0.
//    - ACCESS: sram_en=1, sram_we=latched we, address and data come from the latches.
//    - ACCESS, cnt!=0: decrement cnt.
//    - ACCESS, cnt==0: capture sram_rdata into the owner's rdata register (reads only), move to RESP.
//    - RESP: the owner's ready=1 for exactly one cycle; last_owner=owner; then IDLE.
//    - RESP: a new grant is never made in RESP.
//  - Latency: request sampled in IDLE at edge k -> ready high in cycle k+WAIT_CYCLES+1.
//    - Back-to-back throughput is one transfer per WAIT_CYCLES+2 cycles.
//  - Stores leave mem_rdata unchanged. Each rdata register holds until its next read completes.
//  - A requester dropping req mid-access is illegal. The access still completes and ready still pulses.
//  - Request inputs change only in IDLE sampling. Changes during ACCESS have no effect (latched).
//  - WAIT_CYCLES=1 gives one ACCESS cycle. cnt is 4 bits wide and never wraps below 0.
// STRUCTURE
//  - Shared package arm_mem_pkg holds:
//    - state encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
//    - owner encoding OWN_IF=1'b0, OWN_MEM=1'b1
//  - Sub-module mem_wait_counter (load, enable, zero flag) holds the WAIT_CYCLES countdown.
//  - Everything else is flat in this module.
// TESTING (WAIT_CYCLES=4)
//  1. Reset, then if_req=1, if_addr=0x10, sram returns 0xE3A00001:
//     -> if_ready high 5 cycles after the request; if_rdata=0xE3A00001; freeze=1 until then.
//  2. mem_req=1, mem_we=1, mem_addr=0x400, mem_wdata=0xDEADBEEF:
//     -> sram_we=1 for 4 cycles with that address and data; mem_ready pulses; mem_rdata stays 0.
//  3. if_req and mem_req both held high from reset:
//     -> grants alternate MEM, IF, MEM, IF; ready pulses are 6 cycles apart.
//  4. rst dropped on the 2nd ACCESS cycle:
//     -> sram_en=0 immediately, no ready pulse; after release with no requests, busy=0.
//  5. Load returning 0x12345678, then a fetch returning 0xAAAA5555:
//     -> mem_rdata keeps 0x12345678 after the fetch completes.
//  6. WAIT_CYCLES=1 build, single load:
//     -> exactly one sram_en cycle; mem_ready 2 cycles after the request.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared encodings for the IF/MEM SRAM arbiter.
//   state_t : arbiter FSM state
//   owner_t : which pipeline stage currently owns the SRAM port
//   CNT_W   : width of the wait-state countdown (WAIT_CYCLES up to 15)
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter for the SRAM access phase.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low (clears the count)
//   load     : load load_val (takes priority over en)
//   load_val : value loaded on a grant (WAIT_CYCLES-1)
//   en       : count down by one while nonzero
//   zero     : count has reached terminal value 0
module mem_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Saturates at zero so a stray enable can never wrap the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one multi-cycle SRAM port between instruction fetch (IF) and
// load/store (MEM). One requester is granted at a time, round-robin on ties.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no transfer; sample requests and grant one
//   ACCESS | SRAM driven from latched request for WAIT_CYCLES cycles
//   RESP   | owner's ready pulses for one cycle; last_owner updated
//
// Ports:
//   clk, rst                         : clock / async active-low reset
//   if_req, if_addr                  : fetch request (held until if_ready)
//   if_rdata, if_ready               : fetched word (registered), done pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                        : load/store request (held until mem_ready)
//   mem_rdata, mem_ready             : load data (registered), done pulse
//   sram_en, sram_we, sram_addr,
//   sram_wdata, sram_rdata           : shared SRAM port
//   freeze                           : pipeline stall while any access pending
//   busy                             : FSM not in IDLE
module mem_access_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              freeze,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, last_owner_q, grant_owner;
    logic              grant;
    logic              cnt_zero;
    logic              access_done;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    mem_wait_counter #(.WIDTH(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (CNT_LOAD),
        .en       (state_q == ACCESS),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On a tie MEM wins unless it was the last one served.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_owner = OWN_IF;
        case (state_q)
            IDLE: begin
                if (mem_req && (!if_req || (last_owner_q == OWN_IF))) begin
                    grant       = 1'b1;
                    grant_owner = OWN_MEM;
                    state_d     = ACCESS;
                end else if (if_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_IF;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign access_done = (state_q == ACCESS) && cnt_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            if_rdata     <= '0;
            mem_rdata    <= '0;
            if_ready     <= 1'b0;
            mem_ready    <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;

            if (grant) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_MEM) begin
                    addr_q  <= mem_addr;
                    we_q    <= mem_we;
                    wdata_q <= mem_wdata;
                end else begin
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end

            // Ready is registered here so it is high exactly while in RESP.
            if (access_done) begin
                if (owner_q == OWN_MEM) begin
                    mem_ready <= 1'b1;
                    if (!we_q) begin
                        mem_rdata <= sram_rdata;
                    end
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= sram_rdata;
                end
            end

            if (state_q == RESP) begin
                last_owner_q <= owner_q;
            end
        end
    end

    assign sram_en    = (state_q == ACCESS);
    assign sram_we    = sram_en && we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = (state_q != IDLE);
    assign freeze     = (if_req && !if_ready) || (mem_req && !mem_ready);

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        if_req, if_ready, mem_req, mem_we, mem_ready;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        sram_en, sram_we, freeze, busy;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    logic        if_req1, if_ready1, mem_req1, mem_we1, mem_ready1;
    logic [31:0] if_addr1, if_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        sram_en1, sram_we1, freeze1, busy1;
    logic [31:0] sram_addr1, sram_wdata1, sram_rdata1;

    logic        use_fn;
    logic [31:0] sram_fixed, sram_fixed1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign sram_rdata  = use_fn ? fn(sram_addr) : sram_fixed;
    assign sram_rdata1 = sram_fixed1;

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .freeze(freeze), .busy(busy)
    );

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
        .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1),
        .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1),
        .freeze(freeze1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit keep_reqs);
        rst = 1'b0;
        if (!keep_reqs) begin
            if_req  = 1'b0;
            mem_req = 1'b0;
        end
        mem_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[6];

    // One isolated transfer: check latency, SRAM drive, freeze and rdata.
    task automatic run_vec(input vec_t v);
        int lat = 0, en_n = 0, we_n = 0, bad = 0, frz_bad = 0;
        bit got = 0;
        sram_fixed = v.sdata;
        mem_we     = v.we;
        if (v.is_mem) begin
            mem_req   = 1'b1;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        #1;
        if (freeze !== 1'b1) frz_bad++;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (sram_en) begin
                en_n++;
                if (sram_addr !== v.addr) bad++;
                if (v.is_mem && v.we && sram_wdata !== v.wdata) bad++;
            end
            if (sram_we) we_n++;
            if (v.is_mem ? if_ready : mem_ready) bad++;
            if (v.is_mem ? mem_ready : if_ready) got = 1;
            else if (freeze !== 1'b1) frz_bad++;
        end
        chk("vec_latency", got ? lat : 99, W + 1);
        chk("vec_freeze_at_ready", 32'(freeze), 0);
        chk("vec_if_rdata", if_rdata, v.exp_if);
        chk("vec_mem_rdata", mem_rdata, v.exp_mem);
        chk("vec_en_cycles", en_n, W);
        chk("vec_we_cycles", we_n, (v.is_mem && v.we) ? W : 0);
        chk("vec_sram_bus", bad, 0);
        chk("vec_freeze_pending", frz_bad, 0);
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        chk("vec_idle_after", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int ev_t[$];
        bit ev_m[$];
        int lat, en_n, bad;
        bit got;

        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hE3A00001, 32'hE3A00001, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0BADF00D, 32'hE3A00001, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h12345678, 32'hE3A00001, 32'h12345678};
        vecs[3] = '{1'b0, 1'b1, 32'h14,  32'h0,        32'hAAAA5555, 32'hAAAA5555, 32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'h404, 32'h11111111, 32'hFFFFFFFF, 32'hAAAA5555, 32'h12345678};
        vecs[5] = '{1'b0, 1'b0, 32'h18,  32'h0,        32'h00000000, 32'h00000000, 32'h12345678};

        use_fn = 1'b0; sram_fixed = '0; sram_fixed1 = '0;
        if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
        if_req1 = 0; if_addr1 = '0; mem_req1 = 0; mem_we1 = 0; mem_addr1 = '0; mem_wdata1 = '0;
        rst = 1'b0;
        #3;
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_ready", {30'd0, if_ready, mem_ready}, 0);
        chk("rst_sram_en", {31'd0, sram_en}, 0);
        chk("rst_sram_we", {31'd0, sram_we}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_freeze", {31'd0, freeze}, 0);
        apply_reset(1'b0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset on the second ACCESS cycle of a store.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h77;
        tick();
        tick();
        chk("t4_en_before", {30'd0, sram_en, sram_we}, 32'h3);
        rst = 1'b0;
        #1;
        chk("t4_en_dropped", {30'd0, sram_en, sram_we}, 0);
        chk("t4_busy_dropped", {31'd0, busy}, 0);
        chk("t4_mem_rdata_cleared", mem_rdata, 0);
        chk("t4_if_rdata_cleared", if_rdata, 0);
        mem_req = 1'b0; mem_we = 1'b0;
        apply_reset(1'b0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_ready || if_ready || busy) bad++;
        end
        chk("t4_no_pulse_idle", bad, 0);

        // Both requesters held high from reset: round-robin starting with MEM.
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (mem_ready) begin ev_t.push_back(t); ev_m.push_back(1'b1); end
            if (if_ready)  begin ev_t.push_back(t); ev_m.push_back(1'b0); end
        end
        chk("t3_count", (ev_t.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < ev_t.size() && k < 4; k++) begin
            chk("t3_owner", {31'd0, ev_m[k]}, (k % 2 == 0) ? 1 : 0);
            chk("t3_time", ev_t[k], W + 1 + k * (W + 2));
        end
        if_req = 1'b0; mem_req = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (!busy) got = 1;
        end
        chk("t3_drain", {31'd0, got}, 1);

        // WAIT_CYCLES=1 build: single load.
        sram_fixed1 = 32'hCAFEF00D;
        mem_req1 = 1'b1; mem_we1 = 1'b0; mem_addr1 = 32'h30;
        lat = 0; en_n = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            lat++;
            if (sram_en1) en_n++;
            if (mem_ready1) got = 1;
        end
        chk("t6_latency", got ? lat : 99, 2);
        chk("t6_en_cycles", en_n, 1);
        chk("t6_mem_rdata", mem_rdata1, 32'hCAFEF00D);
        mem_req1 = 1'b0;

        // Randomized traffic against a transfer-timing reference model.
        use_fn = 1'b1;
        apply_reset(1'b0);
        begin
            bit          act, own, m_we, last_mem, ip, mp, mw;
            bit          e_ir, e_mr, e_en, e_busy;
            int          s, free_at;
            logic [31:0] m_addr, m_wdata, ia, ma, md, e_if, e_mem;
            act = 0; own = 0; m_we = 0; last_mem = 0; ip = 0; mp = 0; mw = 0;
            s = 0; free_at = 0;
            m_addr = '0; m_wdata = '0; ia = '0; ma = '0; md = '0; e_if = '0; e_mem = '0;
            for (int t = 0; t < 3000; t++) begin
                if (t > 0) tick();
                e_ir = 0; e_mr = 0;
                e_en   = act && (t >= s + 1) && (t <= s + W);
                e_busy = act && (t >= s + 1) && (t <= s + W + 1);
                if (act && t == s + W + 1) begin
                    if (own) e_mr = 1; else e_ir = 1;
                    if (!m_we) begin
                        if (own) e_mem = fn(m_addr); else e_if = fn(m_addr);
                    end
                end
                chk("rnd_if_ready", {31'd0, if_ready}, {31'd0, e_ir});
                chk("rnd_mem_ready", {31'd0, mem_ready}, {31'd0, e_mr});
                chk("rnd_if_rdata", if_rdata, e_if);
                chk("rnd_mem_rdata", mem_rdata, e_mem);
                chk("rnd_sram_en", {31'd0, sram_en}, {31'd0, e_en});
                chk("rnd_busy", {31'd0, busy}, {31'd0, e_busy});
                if (e_en) begin
                    chk("rnd_sram_we", {31'd0, sram_we}, {31'd0, m_we});
                    chk("rnd_sram_addr", sram_addr, m_addr);
                    if (m_we) chk("rnd_sram_wdata", sram_wdata, m_wdata);
                end
                if (e_ir || e_mr) begin
                    last_mem = own;
                    act = 0;
                    free_at = t + 1;
                    if (own) mp = 0; else ip = 0;
                end
                if (!ip && $urandom_range(0, 2) == 0) begin
                    ip = 1; ia = $urandom;
                end
                if (!mp && $urandom_range(0, 2) == 0) begin
                    mp = 1; ma = $urandom; mw = 1'($urandom_range(0, 1)); md = $urandom;
                end
                if_req = ip; if_addr = ia;
                mem_req = mp; mem_addr = ma; mem_we = mw; mem_wdata = md;
                #1;
                chk("rnd_freeze", {31'd0, freeze}, {31'd0, (ip && !e_ir) || (mp && !e_mr)});
                if (!act && t >= free_at && (ip || mp)) begin
                    own     = mp && (!ip || !last_mem);
                    s       = t;
                    act     = 1;
                    m_addr  = own ? ma : ia;
                    m_we    = own ? mw : 1'b0;
                    m_wdata = md;
                end
            end
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
